error_response_queue: RTL and testbench

//  Parametrised error-response builder for the authentication responder. Captures
//  per-source error request pulses, resolves them by priority, queues error codes,
//  and emits one ERROR response header at a time over a valid/ready handshake to the

---
 rtl/error_response_queue_if.sv | 24 ++
 rtl/error_response_queue.sv | 233 +++++++++++++++++++++++
 tb/tb_error_response_queue.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/error_response_queue_if.sv
// Error-response message channel: header word, payload flag and valid/ready handshake
// between the error-response builder (master) and the message transmitter (slave).
interface error_response_queue_if #(
    parameter int unsigned VAR_W = 8
);
    logic [4*VAR_W-1:0] header;
    logic               payload;
    logic               msg_valid;
    logic               msg_ready;

    modport master (
        output header,
        output payload,
        output msg_valid,
        input  msg_ready
    );

    modport slave (
        input  header,
        input  payload,
        input  msg_valid,
        output msg_ready
    );
endinterface

// File: rtl/error_response_queue.sv
// Error-response builder: captures per-source error pulses, queues them by priority and
// emits one ERROR header at a time. ERROR_RESP_OVF_CNT_EN adds the ovf_cnt drop counter.
`ifndef SIZE_OF_HEADER_VARS
`define SIZE_OF_HEADER_VARS 8
`endif
`ifndef PROTOCOL_VERSION
`define PROTOCOL_VERSION 8'h10
`endif
`ifndef ERROR_RESP_CMD
`define ERROR_RESP_CMD 8'h7F
`endif

module error_response_queue #(
    parameter int unsigned NUM_SRC    = 5,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned VAR_W      = `SIZE_OF_HEADER_VARS
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [NUM_SRC-1:0]     err_req,
    output logic                   q_full,
    error_response_queue_if.master msg_if
`ifdef ERROR_RESP_OVF_CNT_EN
    ,
    output logic [7:0]             ovf_cnt
`endif
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned IDX_W  = $clog2(NUM_SRC);
    localparam int unsigned CODE_W = 3;
    localparam int unsigned HDR_W  = 4 * VAR_W;

    localparam logic [VAR_W-1:0] HDR_VER = VAR_W'(`PROTOCOL_VERSION);
    localparam logic [VAR_W-1:0] HDR_CMD = VAR_W'(`ERROR_RESP_CMD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } state_t;

    state_t              state_q;
    logic [NUM_SRC-1:0]  pending_q, pending_d;
    logic [CODE_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                q_full_q;
    logic [CODE_W-1:0]   code_q;
    logic [HDR_W-1:0]    header_q;
    logic                msg_valid_q;

    logic                sel_valid_c;
    logic [IDX_W-1:0]    sel_idx_c;
    logic [NUM_SRC-1:0]  sel_mask_c;
    logic [CODE_W-1:0]   sel_code_c;
    logic                push_c;
    logic                pop_c;

    // Header word for a queued error code
    function automatic logic [HDR_W-1:0] build_hdr(input logic [CODE_W-1:0] code);
        logic [VAR_W-1:0] p1;
        logic [VAR_W-1:0] p2;
        p1 = VAR_W'(8'h04);
        p2 = VAR_W'(8'h00);
        case (code)
            3'd0, 3'd1: begin p1 = VAR_W'(8'h01); p2 = VAR_W'(8'h00); end
            3'd2:       begin p1 = VAR_W'(8'h03); p2 = VAR_W'(8'h00); end
            3'd3:       begin p1 = VAR_W'(8'h02); p2 = VAR_W'(8'h01); end
            default:    begin p1 = VAR_W'(8'h04); p2 = VAR_W'(8'h00); end
        endcase
        return {HDR_VER, HDR_CMD, p1, p2};
    endfunction

    // Lowest-index pending source has the highest priority
    always_comb begin
        sel_valid_c = |pending_q;
        sel_idx_c   = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx_c = IDX_W'(i);
            end
        end
        sel_mask_c = NUM_SRC'(1) << sel_idx_c;
        sel_code_c = (sel_idx_c >= IDX_W'(4)) ? CODE_W'(4) : CODE_W'(sel_idx_c);
    end

    always_comb begin
        pop_c  = 1'b0;
        push_c = 1'b0;
        if (!flush && (count_q != '0)) begin
            pop_c = (state_q == ST_IDLE) ||
                    ((state_q == ST_SEND) && msg_valid_q && msg_if.msg_ready);
        end
        if (!flush && sel_valid_c) begin
            push_c = (count_q != CNT_W'(FIFO_DEPTH)) || pop_c;
        end
    end

    // Re-request on the bit being enqueued this edge keeps it pending
    always_comb begin
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end else begin
            if (push_c) begin
                pending_d = pending_d & ~sel_mask_c;
            end
            if (enable) begin
                pending_d = pending_d | err_req;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            q_full_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            q_full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= sel_code_c;
        end
    end

    // Message FSM: pop into code_q, build header in LOAD, hold it through SEND
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            code_q      <= '0;
            header_q    <= '0;
            msg_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            header_q    <= '0;
            msg_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    msg_valid_q <= 1'b0;
                    if (pop_c) begin
                        code_q  <= mem_q[rd_ptr_q];
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    header_q    <= build_hdr(code_q);
                    msg_valid_q <= 1'b1;
                    state_q     <= ST_SEND;
                end
                ST_SEND: begin
                    if (msg_if.msg_ready) begin
                        msg_valid_q <= 1'b0;
                        if (pop_c) begin
                            code_q  <= mem_q[rd_ptr_q];
                            state_q <= ST_LOAD;
                        end else begin
                            header_q <= '0;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    header_q    <= '0;
                    msg_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ERROR_RESP_OVF_CNT_EN
    logic [7:0] ovf_q;
    logic       drop_c;

    assign drop_c = !flush && enable && (|(err_req & pending_q));

    // Saturating count of requests merged into an already-pending bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= '0;
        end else if (drop_c && (ovf_q != 8'hFF)) begin
            ovf_q <= ovf_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_q;
`endif

    assign msg_if.header    = header_q;
    assign msg_if.payload   = 1'b0;
    assign msg_if.msg_valid = msg_valid_q;
    assign q_full           = q_full_q;

endmodule

// File: tb/tb_error_response_queue.sv
// Directed bench for error_response_queue: latency, priority order, back-pressure,
// queue-full holding, enable gating, flush and async reset during SEND.
module tb_error_response_queue;

    localparam int unsigned NSRC = 6;

`ifdef PROTOCOL_VERSION
    localparam logic [7:0] VER = 8'(`PROTOCOL_VERSION);
`else
    localparam logic [7:0] VER = 8'h10;
`endif
`ifdef ERROR_RESP_CMD
    localparam logic [7:0] CMD = 8'(`ERROR_RESP_CMD);
`else
    localparam logic [7:0] CMD = 8'h7F;
`endif

    logic            clk;
    logic            reset_n;
    logic            enable;
    logic            flush;
    logic [NSRC-1:0] err_req;
    logic            q_full;
`ifdef ERROR_RESP_OVF_CNT_EN
    logic [7:0]      ovf_cnt;
`endif

    int vectors;
    int miscompares;

    error_response_queue_if #(.VAR_W(8)) mif ();

    error_response_queue #(
        .NUM_SRC    (NSRC),
        .FIFO_DEPTH (4),
        .VAR_W      (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .flush   (flush),
        .err_req (err_req),
        .q_full  (q_full),
        .msg_if  (mif)
`ifdef ERROR_RESP_OVF_CNT_EN
        ,
        .ovf_cnt (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (mif.msg_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(mif.msg_valid), 64'd1);
    endtask

    function automatic logic [31:0] hdr(input logic [7:0] p1, input logic [7:0] p2);
        return {VER, CMD, p1, p2};
    endfunction

    logic [31:0] exp_hdr [6];

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset_n       = 1'b0;
        enable        = 1'b1;
        flush         = 1'b0;
        err_req       = '0;
        mif.msg_ready = 1'b1;

        // Reset state
        step();
        step();
        check("rst_valid", 64'(mif.msg_valid), 64'd0);
        check("rst_header", 64'(mif.header), 64'd0);
        check("rst_qfull", 64'(q_full), 64'd0);
        check("rst_payload", 64'(mif.payload), 64'd0);
`ifdef ERROR_RESP_OVF_CNT_EN
        check("rst_ovf", 64'(ovf_cnt), 64'd0);
`endif
        reset_n = 1'b1;
        step();

        // Single Busy request: valid appears after the third edge
        err_req = 6'b000100;
        step();
        err_req = '0;
        check("lat_e0", 64'(mif.msg_valid), 64'd0);
        step();
        check("lat_e1", 64'(mif.msg_valid), 64'd0);
        step();
        check("lat_e2", 64'(mif.msg_valid), 64'd0);
        step();
        check("lat_e3_valid", 64'(mif.msg_valid), 64'd1);
        check("lat_e3_hdr", 64'(mif.header), 64'(hdr(8'h03, 8'h00)));
        step();
        check("lat_done_valid", 64'(mif.msg_valid), 64'd0);
        check("lat_done_hdr", 64'(mif.header), 64'd0);

        // Two sources same cycle: src3 before src4, one idle cycle between
        err_req = 6'b011000;
        step();
        err_req = '0;
        step();
        step();
        step();
        check("pair_first_valid", 64'(mif.msg_valid), 64'd1);
        check("pair_first_hdr", 64'(mif.header), 64'(hdr(8'h02, 8'h01)));
        step();
        check("pair_gap", 64'(mif.msg_valid), 64'd0);
        step();
        check("pair_second_valid", 64'(mif.msg_valid), 64'd1);
        check("pair_second_hdr", 64'(mif.header), 64'(hdr(8'h04, 8'h00)));
        step();
        check("pair_done", 64'(mif.msg_valid), 64'd0);

        // Back-pressure: header and valid held while ready is low
        mif.msg_ready = 1'b0;
        err_req = 6'b000001;
        step();
        err_req = '0;
        wait_valid("bp_wait", 10);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_valid", 64'(mif.msg_valid), 64'd1);
            check("bp_hold_hdr", 64'(mif.header), 64'(hdr(8'h01, 8'h00)));
        end
        mif.msg_ready = 1'b1;
        step();
        check("bp_accept_valid", 64'(mif.msg_valid), 64'd0);
        check("bp_accept_hdr", 64'(mif.header), 64'd0);

        // Six sources while stalled: queue fills, src5 waits in pending
        mif.msg_ready = 1'b0;
        err_req = 6'b111111;
        step();
        err_req = '0;
        for (int i = 0; i < 5; i++) step();
        check("full_qfull", 64'(q_full), 64'd1);
        check("full_valid", 64'(mif.msg_valid), 64'd1);
        check("full_hdr", 64'(mif.header), 64'(hdr(8'h01, 8'h00)));
`ifdef ERROR_RESP_OVF_CNT_EN
        err_req = 6'b100000;
        step();
        err_req = '0;
        check("ovf_merge", 64'(ovf_cnt), 64'd1);
`endif
        exp_hdr[0] = hdr(8'h01, 8'h00);
        exp_hdr[1] = hdr(8'h01, 8'h00);
        exp_hdr[2] = hdr(8'h03, 8'h00);
        exp_hdr[3] = hdr(8'h02, 8'h01);
        exp_hdr[4] = hdr(8'h04, 8'h00);
        exp_hdr[5] = hdr(8'h04, 8'h00);
        mif.msg_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_valid("drain_wait", 8);
            check("drain_hdr", 64'(mif.header), 64'(exp_hdr[k]));
            step();
            check("drain_gap", 64'(mif.msg_valid), 64'd0);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_no_extra", 64'(mif.msg_valid), 64'd0);
        end
        check("drain_qfull", 64'(q_full), 64'd0);

        // Enable low: requests ignored
        enable = 1'b0;
        err_req = 6'b000010;
        step();
        err_req = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("dis_quiet", 64'(mif.msg_valid), 64'd0);
        end
        enable = 1'b1;

        // Flush in SEND with two queued; overrides handshake and new request
        mif.msg_ready = 1'b0;
        err_req = 6'b000111;
        step();
        err_req = '0;
        wait_valid("fl_wait", 10);
        step();
        check("fl_pre_hdr", 64'(mif.header), 64'(hdr(8'h01, 8'h00)));
        flush = 1'b1;
        mif.msg_ready = 1'b1;
        err_req = 6'b001000;
        step();
        flush = 1'b0;
        err_req = '0;
        check("fl_valid", 64'(mif.msg_valid), 64'd0);
        check("fl_hdr", 64'(mif.header), 64'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("fl_quiet", 64'(mif.msg_valid), 64'd0);
        end

        // Async reset while in SEND drops valid without a clock edge
        mif.msg_ready = 1'b0;
        err_req = 6'b000100;
        step();
        err_req = '0;
        wait_valid("ar_wait", 10);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("ar_valid", 64'(mif.msg_valid), 64'd0);
        check("ar_hdr", 64'(mif.header), 64'd0);
        step();
        reset_n = 1'b1;
        mif.msg_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ar_quiet", 64'(mif.msg_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
